clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
Mode and edit sequencer for the century clock's chain of digit/field counters (sec, min, hour, day, month, year, century).
- In RUN mode it forwards the 1 Hz tick to the seconds counter enable, so the carry chain advances normally.
- In EDIT mode it freezes the chain. It steps a one-hot field selection and issues single-cycle up/down pulses to the selected counter. It can issue a global clear through the counters' preset inputs.
- It sits between the debounced button front end and the counter chain. It also drives a blink strobe for the display.

Parameters:
NUM_FIELDS, 7, number of counter fields; index 0 = seconds, NUM_FIELDS-1 = century
IDX_W, 3, width of the field index; must satisfy 2**IDX_W >= NUM_FIELDS
TIMEOUT_SEC, 30, idle tick_1hz pulses in EDIT before automatic return to RUN
TO_W, 5, width of the timeout counter; must hold TIMEOUT_SEC
BLINK_DIV, 25000000, clk cycles per blink half-period
BLINK_W, 25, width of the blink divider; must hold BLINK_DIV-1

Ports:
clk  in  1  system clock, all logic on its rising edge
rst  in  1  synchronous reset, active-high
tick_1hz  in  1  one-cycle timebase pulse
btn_mode  in  1  one-cycle pulse; toggles RUN/EDIT
btn_next  in  1  one-cycle pulse; selects the next field
btn_up  in  1  one-cycle pulse; increments the selected field
btn_down  in  1  one-cycle pulse; decrements the selected field
btn_clear  in  1  one-cycle pulse; clears all fields
sec_en  out  1  enable to the seconds counter (registered copy of tick_1hz in RUN)
up_o  out  NUM_FIELDS  per-field up pulse
down_o  out  NUM_FIELDS  per-field down pulse
preset_o  out  NUM_FIELDS  per-field synchronous clear
field_sel  out  NUM_FIELDS  one-hot selected field, all-zero in RUN
editing  out  1  high in EDIT and CLEAR
blink  out  1  display strobe for the selected field

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state=RUN, idx=0
  - sec_en=0, up_o=0, down_o=0, preset_o=0, field_sel=0
  - editing=0, blink=1
  - timeout and blink counters = 0
- Reset asserted mid-edit aborts the edit on the next edge. No partial up/down pulse is emitted after reset.
- State RUN:
  - sec_en(t+1) = tick_1hz(t), i.e. 1-cycle latency.
  - up_o, down_o, preset_o and field_sel are 0; blink=1.
  - btn_mode -> EDIT with idx=0.
  - All other buttons are ignored.
- State EDIT:
  - sec_en=0; field_sel = one-hot(idx); editing=1.
  - Button priority when several arrive in one cycle: mode > clear > next > up/down.
  - btn_mode -> RUN; field_sel=0 on the next cycle.
  - btn_clear -> CLEAR.
  - btn_next: idx <= idx+1, wrapping from NUM_FIELDS-1 to 0.
  - btn_up alone: up_o[idx]=1 for exactly one cycle, 1-cycle latency.
  - btn_down alone: down_o[idx]=1 for exactly one cycle, 1-cycle latency.
  - btn_up and btn_down in the same cycle: both suppressed, no pulse.
  - Value wrap (0<->MAX) is done by the counter itself, not here.
  - Timeout counter:
    - cleared on entry to EDIT and on any accepted button;
    - incremented on each tick_1hz;
    - when it reaches TIMEOUT_SEC, next state is RUN and idx=0.
    - A button arriving in the same cycle as the final tick wins: the counter clears and the state stays EDIT.
- State CLEAR:
  - preset_o = all-ones for exactly one cycle; up/down = 0.
  - Next state is EDIT with idx=0.
  - Buttons during CLEAR are ignored.
- Blink:
  - In EDIT, the divider counts clk cycles from 0 to BLINK_DIV-1; blink toggles on wrap.
  - The divider resets to 0 with blink=1 on EDIT entry and on every idx change, so a newly selected field is immediately visible.
  - In RUN and CLEAR, blink is held at 1.
- Counters never exceed their terminal value. Width rules: unsigned arithmetic, no overflow beyond the parameter limits.

Decomposition:
- Package clock_ctrl_pkg:
  - state encoding: ST_RUN=2'd0, ST_EDIT=2'd1, ST_CLEAR=2'd2;
  - field index constants F_SEC=0, F_MIN=1, F_HOUR=2, F_DAY=3, F_MON=4, F_YEAR=5, F_CENT=6.
- One sub-module, blink_gen, parameterised by BLINK_DIV and BLINK_W, with inputs clk, rst, run, restart and output blink.
- The FSM, index register, timeout counter and pulse decoding stay in the top module.

Test Plan:
Bench uses NUM_FIELDS=7, TIMEOUT_SEC=3, BLINK_DIV=4.
1. Reset, then tick_1hz pulses at cycles 10 and 20 -> sec_en=1 at cycles 11 and 21 only; field_sel=0; editing=0.
2. btn_mode, then btn_next x2, then btn_up -> field_sel=7'b0000100; up_o=7'b0000100 for one cycle; tick_1hz during EDIT gives sec_en=0.
3. In EDIT at idx=6, btn_next -> idx wraps to 0, field_sel=7'b0000001, blink=1 on the next cycle and toggles 4 cycles later.
4. btn_up and btn_down in the same cycle -> up_o=down_o=0. btn_next and btn_down together -> idx advances, down_o=0.
5. btn_clear in EDIT -> preset_o=7'b1111111 for exactly one cycle, then EDIT with field_sel=7'b0000001.
6. Enter EDIT, apply 3 ticks with no buttons -> RUN after the third tick, field_sel=0. Repeat with btn_up on the third tick -> stays in EDIT. rst asserted mid-EDIT -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding and field indices for the clock edit controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_EDIT  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam int F_SEC  = 0;
  localparam int F_MIN  = 1;
  localparam int F_HOUR = 2;
  localparam int F_DAY  = 3;
  localparam int F_MON  = 4;
  localparam int F_YEAR = 5;
  localparam int F_CENT = 6;

endpackage

// File: rtl/clock_set_ctrl_blink.sv
// Blink strobe for the selected display field. Held high when not running;
// a restart forces it high and restarts the half-period so a new selection
// shows up immediately.
module blink_gen #(
  parameter int BLINK_DIV = 25000000,
  parameter int BLINK_W   = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic blink
);

  logic [BLINK_W-1:0] cnt_q, cnt_d;
  logic               blink_q, blink_d;

  // Next-state: count 0..BLINK_DIV-1, toggle on wrap.
  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (!run || restart) begin
      cnt_d   = '0;
      blink_d = 1'b1;
    end else if (cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/edit sequencer for the clock's field counter chain.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_RUN   | chain free-running, tick forwarded to seconds enable
//   ST_EDIT  | chain frozen, one field selected, up/down pulses issued
//   ST_CLEAR | one-cycle preset of every field, then back to EDIT idx 0
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int NUM_FIELDS  = 7,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT_SEC = 30,
  parameter int TO_W        = 5,
  parameter int BLINK_DIV   = 25000000,
  parameter int BLINK_W     = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic                  btn_mode,
  input  logic                  btn_next,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_clear,
  output logic                  sec_en,
  output logic [NUM_FIELDS-1:0] up_o,
  output logic [NUM_FIELDS-1:0] down_o,
  output logic [NUM_FIELDS-1:0] preset_o,
  output logic [NUM_FIELDS-1:0] field_sel,
  output logic                  editing,
  output logic                  blink
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic                  sec_en_q, sec_en_d;
  logic [NUM_FIELDS-1:0] up_q, up_d;
  logic [NUM_FIELDS-1:0] down_q, down_d;
  logic [NUM_FIELDS-1:0] preset_q, preset_d;
  logic [NUM_FIELDS-1:0] sel_q, sel_d;
  logic                  editing_q, editing_d;
  logic [NUM_FIELDS-1:0] cur_onehot;
  logic                  blink_run, blink_restart;

  assign cur_onehot = NUM_FIELDS'(1) << idx_q;

  // Next-state, index, idle timer and output pulse decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    to_d     = to_q;
    up_d     = '0;
    down_d   = '0;
    unique case (state_q)
      ST_RUN: begin
        if (btn_mode) begin
          state_d = ST_EDIT;
          idx_d   = IDX_W'(F_SEC);
          to_d    = '0;
        end
      end
      ST_EDIT: begin
        if (btn_mode) begin
          state_d = ST_RUN;
          idx_d   = IDX_W'(F_SEC);
          to_d    = '0;
        end else if (btn_clear) begin
          state_d = ST_CLEAR;
          to_d    = '0;
        end else if (btn_next) begin
          idx_d = (idx_q == IDX_W'(NUM_FIELDS - 1)) ? '0 : idx_q + 1'b1;
          to_d  = '0;
        end else if (btn_up || btn_down) begin
          // Simultaneous up+down cancels the pulse but still counts as activity.
          up_d   = (btn_up && !btn_down) ? cur_onehot : '0;
          down_d = (btn_down && !btn_up) ? cur_onehot : '0;
          to_d   = '0;
        end else if (tick_1hz) begin
          if (to_q == TO_W'(TIMEOUT_SEC - 1)) begin
            state_d = ST_RUN;
            idx_d   = IDX_W'(F_SEC);
            to_d    = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_EDIT;
        idx_d   = IDX_W'(F_SEC);
        to_d    = '0;
      end
      default: begin
        state_d = ST_RUN;
        idx_d   = IDX_W'(F_SEC);
        to_d    = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with state_q on the following cycle.
    sec_en_d  = tick_1hz && (state_q == ST_RUN);
    preset_d  = (state_d == ST_CLEAR) ? '1 : '0;
    sel_d     = (state_d == ST_EDIT) ? (NUM_FIELDS'(1) << idx_d) : '0;
    editing_d = (state_d != ST_RUN);
  end

  assign blink_run     = (state_d == ST_EDIT);
  assign blink_restart = (state_d == ST_EDIT) && ((state_q != ST_EDIT) || (idx_d != idx_q));

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      idx_q     <= '0;
      to_q      <= '0;
      sec_en_q  <= 1'b0;
      up_q      <= '0;
      down_q    <= '0;
      preset_q  <= '0;
      sel_q     <= '0;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      to_q      <= to_d;
      sec_en_q  <= sec_en_d;
      up_q      <= up_d;
      down_q    <= down_d;
      preset_q  <= preset_d;
      sel_q     <= sel_d;
      editing_q <= editing_d;
    end
  end

  blink_gen #(
    .BLINK_DIV (BLINK_DIV),
    .BLINK_W   (BLINK_W)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .run     (blink_run),
    .restart (blink_restart),
    .blink   (blink)
  );

  assign sec_en    = sec_en_q;
  assign up_o      = up_q;
  assign down_o    = down_q;
  assign preset_o  = preset_q;
  assign field_sel = sel_q;
  assign editing   = editing_q;

endmodule
